// File: rtl/add_sub_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : add_sub_multicycle
// Description : WIDTH-bit two's-complement adder/subtractor. It processes
//               CHUNK bits per clock and ripples the carry between chunks.
//               A start/done handshake frames each operation. The result
//               and its flags (carry-out, signed overflow, zero) are
//               registered.
// Revision    : 1.0 - initial release
// ============================================================================
module add_sub_multicycle #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int              c_N      = WIDTH / CHUNK;
    localparam int              c_KW     = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_KW-1:0] c_K_LAST = c_KW'(c_N - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic             w_load;
    logic             w_step;
    logic             w_last;

    // Operands are latched at start. For subtraction, B is already
    // inverted, and the +1 enters through the initial carry.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [c_KW-1:0]  r_k;
    logic [WIDTH-1:0] r_acc;

    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_done;
    logic             r_busy;

    int               w_base;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_chunk_sum;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_msb_cin;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and datapath control strobes
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                w_step = 1'b1;
                if (r_k == c_K_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Chunk adder: this cycle's slice plus the rippled carry. The carry into
    // the MSB comes from the top bit of the slice, where a ^ b ^ sum gives
    // the carry into that bit position.
    always_comb begin
        w_base      = int'(r_k) * CHUNK;
        w_a_chunk   = r_a[w_base +: CHUNK];
        w_b_chunk   = r_b[w_base +: CHUNK];
        w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
        w_acc_next  = r_acc;
        w_acc_next[w_base +: CHUNK] = w_chunk_sum[CHUNK-1:0];
        w_msb_cin   = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_chunk_sum[CHUNK-1];
    end

    // Datapath: latch operands, accumulate chunks, publish the result on the last chunk
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_acc   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_a     <= A;
                r_b     <= B ^ {WIDTH{sel}};
                r_carry <= sel;
                r_k     <= '0;
                r_acc   <= '0;
                r_busy  <= 1'b1;
            end
            if (w_step) begin
                r_acc   <= w_acc_next;
                r_carry <= w_chunk_sum[CHUNK];
                r_k     <= r_k + 1'b1;
            end
            if (w_last) begin
                r_k    <= '0;
                r_s    <= w_acc_next;
                r_cout <= w_chunk_sum[CHUNK];
                r_ovf  <= w_msb_cin ^ w_chunk_sum[CHUNK];
                r_zero <= (w_acc_next == '0);
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign S    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_add_sub_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_sub_multicycle
// Description : Self-checking bench. Four configurations run in parallel:
//               8/4, 8/1, 8/8 and 16/4. A transaction-level model predicts
//               every output on every cycle. Directed cases pin literal
//               results on the 8/4 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_sub_multicycle;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sel;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [15:0] a16;
    logic [15:0] b16;

    logic [3:0]  act_busy;
    logic [3:0]  act_done;
    logic [3:0]  act_cout;
    logic [3:0]  act_ovf;
    logic [3:0]  act_zero;
    logic [7:0]  s0;
    logic [7:0]  s1;
    logic [7:0]  s2;
    logic [15:0] s3;
    logic [15:0] act_s [4];
    logic [15:0] op_a  [4];
    logic [15:0] op_b  [4];

    int n_tests;
    int n_fail;
    logic chk_en;

    // Model state, one entry per instance
    logic        mb [4];
    logic        md [4];
    logic [15:0] ms [4];
    logic        mc [4];
    logic        mo [4];
    logic        mz [4];
    int          mcnt [4];
    logic [17:0] mres [4];

    add_sub_multicycle #(.WIDTH(8), .CHUNK(4)) u_d84 (
        .clk(clk), .rst(rst), .start(start), .A(a8), .B(b8), .sel(sel),
        .busy(act_busy[0]), .done(act_done[0]), .S(s0),
        .cout(act_cout[0]), .ovf(act_ovf[0]), .zero(act_zero[0]));
    add_sub_multicycle #(.WIDTH(8), .CHUNK(1)) u_d81 (
        .clk(clk), .rst(rst), .start(start), .A(a8), .B(b8), .sel(sel),
        .busy(act_busy[1]), .done(act_done[1]), .S(s1),
        .cout(act_cout[1]), .ovf(act_ovf[1]), .zero(act_zero[1]));
    add_sub_multicycle #(.WIDTH(8), .CHUNK(8)) u_d88 (
        .clk(clk), .rst(rst), .start(start), .A(a8), .B(b8), .sel(sel),
        .busy(act_busy[2]), .done(act_done[2]), .S(s2),
        .cout(act_cout[2]), .ovf(act_ovf[2]), .zero(act_zero[2]));
    add_sub_multicycle #(.WIDTH(16), .CHUNK(4)) u_d164 (
        .clk(clk), .rst(rst), .start(start), .A(a16), .B(b16), .sel(sel),
        .busy(act_busy[3]), .done(act_done[3]), .S(s3),
        .cout(act_cout[3]), .ovf(act_ovf[3]), .zero(act_zero[3]));

    assign act_s[0] = {8'h00, s0};
    assign act_s[1] = {8'h00, s1};
    assign act_s[2] = {8'h00, s2};
    assign act_s[3] = s3;
    assign op_a[0]  = {8'h00, a8};
    assign op_a[1]  = {8'h00, a8};
    assign op_a[2]  = {8'h00, a8};
    assign op_a[3]  = a16;
    assign op_b[0]  = {8'h00, b8};
    assign op_b[1]  = {8'h00, b8};
    assign op_b[2]  = {8'h00, b8};
    assign op_b[3]  = b16;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int width_of(input int i);
        return (i == 3) ? 16 : 8;
    endfunction

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 8;
            2:       return 1;
            default: return 4;
        endcase
    endfunction

    // Reference arithmetic from integer semantics: returns {cout, ovf, S}
    function automatic logic [17:0] calc(input int w, input logic [15:0] a,
                                         input logic [15:0] b, input logic s);
        int full, half, ua, ub, sa, sb, r, sr;
        logic c, o;
        full = 1 << w;
        half = 1 << (w - 1);
        ua = int'(a) & (full - 1);
        ub = int'(b) & (full - 1);
        sa = (ua >= half) ? ua - full : ua;
        sb = (ub >= half) ? ub - full : ub;
        if (s) begin
            r  = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = ua + ub;
            c  = (r >= full);
            sr = sa + sb;
        end
        o = (sr >= half) || (sr < -half);
        return {c, o, 16'(r & (full - 1))};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: accept start when idle, then publish after the configured latency
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                mb[i]   <= 1'b0;
                md[i]   <= 1'b0;
                ms[i]   <= '0;
                mc[i]   <= 1'b0;
                mo[i]   <= 1'b0;
                mz[i]   <= 1'b0;
                mcnt[i] <= 0;
            end else begin
                md[i] <= 1'b0;
                if (!mb[i]) begin
                    if (start) begin
                        mb[i]   <= 1'b1;
                        mcnt[i] <= lat_of(i);
                        mres[i] <= calc(width_of(i), op_a[i], op_b[i], sel);
                    end
                end else if (mcnt[i] == 1) begin
                    mb[i] <= 1'b0;
                    md[i] <= 1'b1;
                    ms[i] <= mres[i][15:0];
                    mc[i] <= mres[i][17];
                    mo[i] <= mres[i][16];
                    mz[i] <= (mres[i][15:0] == 16'h0);
                end else begin
                    mcnt[i] <= mcnt[i] - 1;
                end
            end
        end
    end

    // Compare every output of every instance against the model each cycle
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("dut%0d busy", i), 32'(act_busy[i]), 32'(mb[i]));
                check($sformatf("dut%0d done", i), 32'(act_done[i]), 32'(md[i]));
                check($sformatf("dut%0d S", i),    32'(act_s[i]),    32'(ms[i]));
                check($sformatf("dut%0d cout", i), 32'(act_cout[i]), 32'(mc[i]));
                check($sformatf("dut%0d ovf", i),  32'(act_ovf[i]),  32'(mo[i]));
                check($sformatf("dut%0d zero", i), 32'(act_zero[i]), 32'(mz[i]));
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while ((act_busy != 4'b0000) && (t < 50)) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: busy=%b required 0000", act_busy);
        end
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [15:0] wa, input logic [15:0] wb);
        a8    = a;
        b8    = b;
        a16   = wa;
        b16   = wb;
        sel   = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    task automatic lit(input string name, input logic [7:0] es, input logic ec,
                       input logic eo, input logic ez);
        check({name, " S"},    32'(s0),          32'(es));
        check({name, " cout"}, 32'(act_cout[0]), 32'(ec));
        check({name, " ovf"},  32'(act_ovf[0]),  32'(eo));
        check({name, " zero"}, 32'(act_zero[0]), 32'(ez));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cv [5];
        n_tests = 0;
        n_fail  = 0;
        chk_en  = 1'b0;
        rst     = 1'b1;
        start   = 1'b0;
        sel     = 1'b0;
        a8      = '0;
        b8      = '0;
        a16     = '0;
        b16     = '0;
        cv[0] = 0; cv[1] = 1; cv[2] = 8'h7F; cv[3] = 8'h80; cv[4] = 8'hFF;

        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        check("reset busy", 32'(act_busy[0]), 32'd0);
        lit("reset", 8'h00, 1'b0, 1'b0, 1'b0);

        // Basic add, overflow cases, subtract cases
        op(8'd1, 8'd2, 1'b0, 16'd1000, 16'd2000);
        lit("add1+2", 8'h03, 1'b0, 1'b0, 1'b0);
        op(8'd100, 8'd50, 1'b0, 16'h7FFF, 16'h0001);
        lit("add100+50", 8'h96, 1'b0, 1'b1, 1'b0);
        op(8'hFB, 8'hFE, 1'b0, 16'hFFFB, 16'hFFFE);
        lit("add-5-2", 8'hF9, 1'b1, 1'b0, 1'b0);
        op(8'd5, 8'd5, 1'b1, 16'h1234, 16'h1234);
        lit("sub5-5", 8'h00, 1'b1, 1'b0, 1'b1);
        op(8'd2, 8'd5, 1'b1, 16'd2, 16'd5);
        lit("sub2-5", 8'hFD, 1'b0, 1'b0, 1'b0);
        op(8'h80, 8'h01, 1'b1, 16'h8000, 16'h0001);
        lit("sub80-1", 8'h7F, 1'b1, 1'b1, 1'b0);

        // start held through RUN with operands changed mid-run
        a8 = 8'h10; b8 = 8'h20; sel = 1'b0; a16 = 16'h0100; b16 = 16'h0200;
        start = 1'b1;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; sel = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        lit("held", 8'h30, 1'b0, 1'b0, 1'b0);

        // Back-to-back: new start in the done cycle
        a8 = 8'h11; b8 = 8'h22; sel = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("b2b first done", 32'(act_done[0]), 32'd1);
        check("b2b first S", 32'(s0), 32'h33);
        a8 = 8'd3; b8 = 8'd4; sel = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b hold S", 32'(s0), 32'h33);
        @(negedge clk);
        check("b2b hold S2", 32'(s0), 32'h33);
        check("b2b no early done", 32'(act_done[0]), 32'd0);
        @(negedge clk);
        check("b2b second done", 32'(act_done[0]), 32'd1);
        check("b2b second S", 32'(s0), 32'h07);
        wait_idle();

        // Reset mid-operation
        a8 = 8'd9; b8 = 8'd9; sel = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", 32'(act_busy[0]), 32'd0);
        check("midrst done", 32'(act_done[0]), 32'd0);
        lit("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        op(8'd7, 8'd1, 1'b1, 16'd7, 16'd1);
        lit("sub7-1", 8'h06, 1'b1, 1'b0, 1'b0);

        // Corner operand sweep, both operations
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                for (int s = 0; s < 2; s++) begin
                    op(8'(cv[i]), 8'(cv[j]), s[0],
                       {8'(cv[i]), 8'(cv[j])}, {8'(cv[j]), 8'(cv[i])});
                end
            end
        end

        // Random operands
        for (int n = 0; n < 60; n++) begin
            op(8'($urandom), 8'($urandom), 1'($urandom),
               16'($urandom), 16'($urandom));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/add_sub_multicycle.md
Name: add_sub_multicycle

Overview:
- Parametrised WIDTH-bit two's-complement adder/subtractor. It succeeds the fixed 4-bit combinational adder/subtractor.
- Computes CHUNK bits per clock over WIDTH/CHUNK cycles with a rippled internal carry, behind a start/done handshake.
- Produces registered sum, carry-out, signed-overflow and zero flags. Used as the shared arithmetic unit for lab datapaths where width exceeds single-cycle timing.

Parameters:
WIDTH, 8, operand/result width in bits
CHUNK, 4, bits processed per cycle; WIDTH must be an integer multiple of CHUNK (1 <= CHUNK <= WIDTH)

Ports:
clk    input   1      clock, rising-edge
rst    input   1      synchronous active-high reset
start  input   1      request; sampled only when busy=0
A      input   WIDTH  operand A, two's complement
B      input   WIDTH  operand B, two's complement
sel    input   1      0 = A+B, 1 = A-B; sampled with start
busy   output  1      operation in progress
done   output  1      one-cycle pulse: result valid
S      output  WIDTH  result, held until next completion
cout   output  1      carry out of MSB (subtract: 1 = no borrow, A>=B unsigned)
ovf    output  1      signed overflow (carry into MSB XOR carry out of MSB)
zero   output  1      S == 0

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high. When rst=1 at a rising edge, all state clears: FSM=IDLE, busy=0, done=0, S=0, cout=0, ovf=0, zero=0, chunk index=0.
- Reset dominates start. Reset mid-operation aborts with no done pulse, and no partial result ever reaches S.
- Latency: N = WIDTH/CHUNK.
- FSM states: IDLE, RUN.
- IDLE:
  - If start=1, latch A, and B XOR {WIDTH{sel}}; the latched carry becomes sel.
  - Chunk index k=0; busy=1 after the edge; go RUN.
  - If start=0, stay; done is forced 0 after one cycle.
- RUN, each edge:
  - Compute sum of chunk k from the latched operands plus the carry.
  - Write it into the internal accumulator bits [k*CHUNK +: CHUNK]; update the carry; k++.
  - On the edge that processes chunk N-1:
    - S <= accumulator with the final chunk.
    - cout <= final carry.
    - ovf <= carry into MSB XOR carry out of MSB.
    - zero <= (final S == 0).
    - done <= 1, busy <= 0, go IDLE.
- Cycle timing:
  - start sampled at edge E0; done=1 during the cycle following edge EN.
  - WIDTH=8/CHUNK=4: done 2 cycles after the start edge. CHUNK=WIDTH: 1 cycle. CHUNK=1: WIDTH cycles.
- done is high for exactly one cycle, with busy=0 in that same cycle.
- A start in the done cycle is accepted (back-to-back). The next done follows N cycles later; S/flags keep the previous result until then.
- start while busy=1 is ignored; A/B/sel changes during RUN have no effect.
- Arithmetic: modulo 2^WIDTH. Signed-overflow carry-into-MSB is taken from the MSB bit of the final chunk.
- S, cout, ovf and zero change only on a completion edge or reset.

Test Plan (WIDTH=8, CHUNK=4 unless stated):
- Add, no flags: rst 2 cycles, then A=1, B=2, sel=0, start pulse -> busy=1 for 2 cycles, done pulse. S=0x03, cout=0, ovf=0, zero=0.
- Add, signed overflow: A=100, B=50, sel=0 -> S=0x96, cout=0, ovf=1, zero=0. Then A=-5 (0xFB), B=-2 (0xFE), sel=0 -> S=0xF9, cout=1, ovf=0.
- Subtract cases:
  - A=5, B=5, sel=1 -> S=0x00, cout=1, zero=1, ovf=0.
  - A=2, B=5, sel=1 -> S=0xFD, cout=0, ovf=0.
  - A=0x80, B=0x01, sel=1 -> S=0x7F, cout=1, ovf=1.
- Handshake:
  - start held high through RUN with A/B changed mid-run -> result from the first-sampled operands only.
  - New start in the done cycle (A=3, B=4, sel=0) -> second done exactly 2 cycles later, S=0x07. S keeps the prior value until then.
- Reset mid-op: rst=1 one cycle after start -> no done pulse, busy=0, S=0, all flags 0. Next op A=7, B=1, sel=1 -> S=0x06 normally.
- Parameter sweep: CHUNK=1 and CHUNK=8 (WIDTH=8), plus WIDTH=16/CHUNK=4.
  - Exhaustive/random A, B, sel against a behavioural reference model.
  - Latency equals WIDTH/CHUNK cycles for every configuration.
